mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 clk  in  1  single system clock, all state on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 opcode  in  7  instruction register [6:0].
REQ-004 funct3  in  3  instruction register [14:12]; branch sense only.
REQ-005 zero  in  1  ALU zero flag, current cycle.
REQ-006 mem_ready  in  1  memory completion, same-cycle with mem_req.
REQ-007 mem_req / mem_we  out  1/1  memory request and write qualifier.
REQ-008 adr_src  out  1  0=PC, 1=ALUOut.
REQ-009 ir_write / pc_write / reg_write  out  1 each  register enables.
REQ-010 alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
REQ-011 alu_src_b  out  2  00=rs2, 01=imm, 10=const 4.
REQ-012 alu_op  out  2  to ALU decoder: 00 add, 01 sub, 10 R-type, 11 I-type/JALR.
REQ-013 result_src  out  2  00=ALUOut, 01=MemData, 10=ALU result.
REQ-014 illegal  out  1  sticky unsupported-opcode flag.
REQ-015 instret  out  32  retired-instruction count (see Configuration).

Function
REQ-016 Moore FSM; states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, TRAP; all outputs decode from state (plus zero/funct3/mem_ready where stated).
REQ-017 Default in every state: all enables 0, mem_req 0, selects 00.
REQ-018 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready; go DECODE on mem_ready, else hold.
REQ-019 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/JAL target into ALUOut); one cycle.
REQ-020 DECODE next: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011/0110111->EXECI; 1100011->BRANCH; 1101111->JAL; 1100111->JALR; other->TRAP.
REQ-021 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next MEMRD if opcode=0000011 else MEMWR.
REQ-022 MEMRD: mem_req=1, adr_src=1; MEMWB on mem_ready else hold. MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-023 MEMWR: mem_req=1, mem_we=1, adr_src=1; FETCH on mem_ready else hold; mem_we never asserted outside MEMWR.
REQ-024 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
REQ-025 EXECI: alu_src_b=01; alu_src_a=11 and alu_op=00 for 0110111 (LUI), else alu_src_a=10, alu_op=11 -> ALUWB.
REQ-026 ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-027 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write=zero XOR funct3[0] (BEQ/BNE); funct3[2:1]!=00 -> TRAP; else FETCH.
REQ-028 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1 -> ALUWB.
REQ-029 JALR: alu_src_a=10, alu_src_b=01, alu_op=11, result_src=10, pc_write=1 -> JALRWB. JALRWB: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=10, reg_write=1 -> FETCH.
REQ-030 TRAP: all enables 0, illegal=1; absorbing until reset.
REQ-031 Zero-wait latency: load 5, store 4, R/I/LUI 4, branch 3, JAL 4, JALR 4 cycles.
REQ-032 mem_ready outside FETCH/MEMRD/MEMWR ignored; mem_ready arriving same cycle as request is accepted.

Reset
REQ-033 rst_n low: state=FETCH, illegal=0, instret=0 immediately; mid-transaction abort drops mem_req asynchronously, no enable pulses.
REQ-034 First FETCH request issued the cycle after rst_n deasserts.

Configuration
REQ-035 MC_CTRL_PERF_EN defined: instret increments by 1 on every transition into FETCH from a non-FETCH, non-TRAP state; wraps 0xFFFFFFFF->0.
REQ-036 MC_CTRL_PERF_EN undefined: no counter register; instret tied to 0.

Structure
REQ-037 Shared package holds state enum, opcode constants, alu_op, alu_src_a/b and result_src encodings.
REQ-038 Single module, no sub-modules; next-state and output decode as separate combinational processes.

Verification
REQ-039 add opcode 0110011, mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write in cycle 4 only; instret=1.
REQ-040 lw with mem_ready low 3 cycles in MEMRD -> mem_req, adr_src=1 held 4 cycles; MEMWB reg_write once; total 8 cycles.
REQ-041 beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; funct3=100 -> TRAP, illegal=1.
REQ-042 opcode 0000000 -> TRAP after DECODE; illegal sticky, no enables, until rst_n low.
REQ-043 rst_n low during MEMWR wait -> mem_req/mem_we 0 same cycle, state FETCH; instret=0.
REQ-044 JALR -> pc_write in JALR, reg_write in JALRWB, result_src=10 both cycles.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared definitions for the multi-cycle controller.
//   state_e          controller FSM states
//   OP_*             RV32 opcode constants decoded by the controller
//   ALU_* / SRCA_* / SRCB_* / RES_*  datapath select encodings
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALRWB,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // alu_op to the ALU decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // result_src
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/mc_controller.sv
// mc_controller: Moore-style control FSM for a multi-cycle RV32 datapath.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   opcode[6:0], funct3[2:0] instruction fields (funct3 used for branch sense)
//   zero                     ALU zero flag (current cycle)
//   mem_ready                memory completion, accepted same cycle as mem_req
//   mem_req, mem_we          memory request / write qualifier
//   adr_src                  0=PC, 1=ALUOut
//   ir_write, pc_write, reg_write  register enables
//   alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], result_src[1:0]  datapath selects
//   illegal                  sticky unsupported-instruction flag
//   instret[31:0]            retired-instruction count
//
// Configuration
//   MC_CTRL_PERF_EN defined   : instret counts every return to FETCH from a
//                               non-FETCH, non-TRAP state (wraps at 2^32).
//   MC_CTRL_PERF_EN undefined : no counter, instret tied to zero.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        illegal,
  output logic [31:0] instret
);

  state_e state_q, state_d;
  logic   illegal_q;

  logic       mem_req_c, mem_we_c, adr_src_c;
  logic       ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE, OP_LUI:  state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      // Only BEQ/BNE are supported; other branch senses are illegal.
      S_BRANCH: state_d = (funct3[2:1] != 2'b00) ? S_TRAP : S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_JALR:   state_d = S_JALRWB;
      S_JALRWB: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    alu_op_c     = ALU_ADD;
    result_src_c = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALU;
        ir_write_c   = mem_ready;
        pc_write_c   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = RES_MEMDATA;
        reg_write_c  = 1'b1;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c = SRCA_RS1;
        alu_op_c    = ALU_RTYPE;
      end
      S_EXECI: begin
        alu_src_b_c = SRCB_IMM;
        if (opcode == OP_LUI) begin
          alu_src_a_c = SRCA_ZERO;
        end else begin
          alu_src_a_c = SRCA_RS1;
          alu_op_c    = ALU_ITYPE;
        end
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a_c = SRCA_RS1;
        alu_op_c    = ALU_SUB;
        pc_write_c  = zero ^ funct3[0];
      end
      S_JAL: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_FOUR;
        pc_write_c  = 1'b1;
      end
      S_JALR: begin
        alu_src_a_c  = SRCA_RS1;
        alu_src_b_c  = SRCB_IMM;
        alu_op_c     = ALU_ITYPE;
        result_src_c = RES_ALU;
        pc_write_c   = 1'b1;
      end
      S_JALRWB: begin
        alu_src_a_c  = SRCA_OLDPC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALU;
        reg_write_c  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

  // The state register sits in FETCH throughout reset; gating with rst_n keeps
  // the bus and all enables quiet until reset is released, so an abort drops
  // mem_req immediately and the first fetch follows deassertion.
  assign mem_req    = rst_n & mem_req_c;
  assign mem_we     = rst_n & mem_we_c;
  assign adr_src    = rst_n & adr_src_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign alu_src_a  = {2{rst_n}} & alu_src_a_c;
  assign alu_src_b  = {2{rst_n}} & alu_src_b_c;
  assign alu_op     = {2{rst_n}} & alu_op_c;
  assign result_src = {2{rst_n}} & result_src_c;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
`timescale 1ns/1ps
module tb_mc_controller;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011,
                         ITYP = 7'b0010011, LUI = 7'b0110111, BR = 7'b1100011,
                         JAL = 7'b1101111, JALR = 7'b1100111;

`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero, mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [31:0] instret;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .illegal(illegal), .instret(instret)
  );

  // {mem_req,mem_we,adr_src,ir_write,pc_write,reg_write,src_a,src_b,alu_op,result_src,illegal}
  logic [14:0] obs_v;
  assign obs_v = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, illegal};

  int checks = 0;
  int errors = 0;

  // Reference model state: per-cycle stimulus and expected outputs.
  bit          rdy_q[$], zro_q[$];
  logic [6:0]  op_q[$];
  logic [2:0]  f3_q[$];
  string       tag_q[$];
  logic [14:0] exp_q[$], obs_q[$];
  logic [31:0] iexp_q[$], iobs_q[$];
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  int unsigned retired;

  function automatic logic [14:0] v(bit mr, bit we, bit ad, bit ir, bit pc, bit rw,
                                    logic [1:0] a, logic [1:0] b, logic [1:0] op,
                                    logic [1:0] rs, bit il);
    return {mr, we, ad, ir, pc, rw, a, b, op, rs, il};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic clear_q();
    rdy_q.delete(); zro_q.delete(); op_q.delete(); f3_q.delete(); tag_q.delete();
    exp_q.delete(); obs_q.delete(); iexp_q.delete(); iobs_q.delete();
  endtask

  task automatic push(input string tag, input bit r, input bit z, input logic [14:0] e);
    tag_q.push_back(tag); rdy_q.push_back(r); zro_q.push_back(z);
    op_q.push_back(cur_op); f3_q.push_back(cur_f3); exp_q.push_back(e);
    iexp_q.push_back(PERF ? retired : 32'd0);
  endtask

  task automatic model_fetch(input int unsigned w);
    for (int unsigned i = 0; i < w; i++)
      push("FETCH_WAIT", 1'b0, rb(), v(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0));
    push("FETCH", 1'b1, rb(), v(1,0,0,1,1,0, 2'b00,2'b10,2'b00,2'b10, 0));
  endtask

  task automatic model_trap(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      push("TRAP", rb(), rb(), v(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1));
  endtask

  // One instruction as a cycle-by-cycle list of what the datapath must see.
  task automatic model_instr(input logic [6:0] op, input logic [2:0] f3, input bit zb,
                             input int unsigned wf, input int unsigned wm,
                             output bit trapped);
    cur_op = op; cur_f3 = f3; trapped = 1'b0;
    model_fetch(wf);
    push("DECODE", rb(), rb(), v(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0));
    case (op)
      LOAD: begin
        push("MEMADR", rb(), rb(), v(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0));
        for (int unsigned i = 0; i < wm; i++)
          push("MEMRD_WAIT", 1'b0, rb(), v(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0));
        push("MEMRD", 1'b1, rb(), v(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0));
        push("MEMWB", rb(), rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0));
      end
      STORE: begin
        push("MEMADR", rb(), rb(), v(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0));
        for (int unsigned i = 0; i < wm; i++)
          push("MEMWR_WAIT", 1'b0, rb(), v(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0));
        push("MEMWR", 1'b1, rb(), v(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0));
      end
      RTYP: begin
        push("EXECR", rb(), rb(), v(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0));
        push("ALUWB", rb(), rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0));
      end
      ITYP: begin
        push("EXECI", rb(), rb(), v(0,0,0,0,0,0, 2'b10,2'b01,2'b11,2'b00, 0));
        push("ALUWB", rb(), rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0));
      end
      LUI: begin
        push("EXECI_LUI", rb(), rb(), v(0,0,0,0,0,0, 2'b11,2'b01,2'b00,2'b00, 0));
        push("ALUWB", rb(), rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0));
      end
      BR: begin
        push("BRANCH", rb(), zb, v(0,0,0,0,zb ^ f3[0],0, 2'b10,2'b00,2'b01,2'b00, 0));
        trapped = (f3[2:1] != 2'b00);
      end
      JAL: begin
        push("JAL", rb(), rb(), v(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 0));
        push("ALUWB", rb(), rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0));
      end
      JALR: begin
        push("JALR", rb(), rb(), v(0,0,0,0,1,0, 2'b10,2'b01,2'b11,2'b10, 0));
        push("JALRWB", rb(), rb(), v(0,0,0,0,0,1, 2'b01,2'b10,2'b00,2'b10, 0));
      end
      default: trapped = 1'b1;
    endcase
    if (!trapped) retired++;
  endtask

  // Drives the first n modelled cycles and records what the DUT shows.
  task automatic play(input int unsigned n);
    for (int unsigned i = 0; i < n && i < rdy_q.size(); i++) begin
      @(negedge clk);
      opcode = op_q[i]; funct3 = f3_q[i]; mem_ready = rdy_q[i]; zero = zro_q[i];
      #2;
      obs_q.push_back(obs_v);
      iobs_q.push_back(instret);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    retired = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0; retired = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_v !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs_v, 15'd0); end
    checks++;
    if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    checks++;
    if (obs_v !== v(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0)) begin
      errors++;
      $display("FAIL first_fetch: got %b expected %b", obs_v, v(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0));
    end
  endtask

  task automatic test_add();
    bit t;
    clear_q();
    model_instr(RTYP, 3'b000, 1'b0, 0, 0, t);
    push("NEXT_FETCH", 1'b0, 1'b0, v(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0));
    play(rdy_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL add %s cyc%0d: got %b expected %b", tag_q[i], i, obs_q[i], exp_q[i]); end
      checks++;
      if (iobs_q[i] !== iexp_q[i]) begin errors++; $display("FAIL add_instret cyc%0d: got %0d expected %0d", i, iobs_q[i], iexp_q[i]); end
    end
  endtask

  task automatic test_load_wait();
    bit t;
    clear_q();
    model_instr(LOAD, 3'b010, 1'b0, 0, 3, t);
    play(rdy_q.size());
    checks++;
    if (obs_q.size() != 8) begin errors++; $display("FAIL lw_length: got %0d expected 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lw %s cyc%0d: got %b expected %b", tag_q[i], i, obs_q[i], exp_q[i]); end
      checks++;
      if (iobs_q[i] !== iexp_q[i]) begin errors++; $display("FAIL lw_instret cyc%0d: got %0d expected %0d", i, iobs_q[i], iexp_q[i]); end
    end
  endtask

  task automatic test_branch();
    bit t;
    clear_q();
    model_instr(BR, 3'b000, 1'b1, 0, 0, t);   // beq taken
    model_instr(BR, 3'b001, 1'b1, 1, 0, t);   // bne not taken
    model_instr(BR, 3'b000, 1'b0, 0, 0, t);   // beq not taken
    model_instr(BR, 3'b001, 1'b0, 2, 0, t);   // bne taken
    model_instr(BR, 3'b100, rb(), 0, 0, t);   // unsupported sense
    model_trap(5);
    play(rdy_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL branch %s cyc%0d: got %b expected %b", tag_q[i], i, obs_q[i], exp_q[i]); end
      checks++;
      if (iobs_q[i] !== iexp_q[i]) begin errors++; $display("FAIL branch_instret cyc%0d: got %0d expected %0d", i, iobs_q[i], iexp_q[i]); end
    end
    do_reset();
  endtask

  task automatic test_trap();
    bit t;
    bit found;
    logic [6:0] bad;
    for (int pass = 0; pass < 2; pass++) begin
      clear_q();
      if (pass == 0) begin
        bad = 7'b0000000;
      end else begin
        do begin
          bad = 7'($urandom_range(0, 127));
          found = (bad == LOAD || bad == STORE || bad == RTYP || bad == ITYP ||
                   bad == LUI || bad == BR || bad == JAL || bad == JALR);
        end while (found);
      end
      model_instr(bad, 3'($urandom_range(0, 7)), rb(), 1, 0, t);
      model_trap(6);
      play(rdy_q.size());
      for (int i = 0; i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL trap op=%b %s cyc%0d: got %b expected %b", bad, tag_q[i], i, obs_q[i], exp_q[i]); end
        checks++;
        if (iobs_q[i] !== iexp_q[i]) begin errors++; $display("FAIL trap_instret cyc%0d: got %0d expected %0d", i, iobs_q[i], iexp_q[i]); end
      end
      do_reset();
    end
    // After reset the flag must be clear and normal execution resumes.
    clear_q();
    model_instr(ITYP, 3'b000, 1'b0, 0, 0, t);
    play(rdy_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_trap %s cyc%0d: got %b expected %b", tag_q[i], i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_jalr();
    bit t;
    clear_q();
    model_instr(JALR, 3'b000, 1'b0, 0, 0, t);
    model_instr(JAL, 3'b000, 1'b0, 0, 0, t);
    play(rdy_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL jump %s cyc%0d: got %b expected %b", tag_q[i], i, obs_q[i], exp_q[i]); end
      checks++;
      if (iobs_q[i] !== iexp_q[i]) begin errors++; $display("FAIL jump_instret cyc%0d: got %0d expected %0d", i, iobs_q[i], iexp_q[i]); end
    end
  endtask

  task automatic test_reset_abort();
    bit t;
    clear_q();
    model_instr(STORE, 3'b010, 1'b0, 0, 5, t);
    play(5);   // FETCH, DECODE, MEMADR, two MEMWR wait cycles
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_pre %s cyc%0d: got %b expected %b", tag_q[i], i, obs_q[i], exp_q[i]); end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL abort_bus: got mem_req=%b mem_we=%b expected 0 0", mem_req, mem_we);
    end
    checks++;
    if (obs_v !== 15'd0) begin errors++; $display("FAIL abort_outputs: got %b expected %b", obs_v, 15'd0); end
    checks++;
    if (instret !== 32'd0) begin errors++; $display("FAIL abort_instret: got %0d expected 0", instret); end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    retired = 0;
    clear_q();
    model_instr(RTYP, 3'b000, 1'b0, 0, 0, t);
    push("NEXT_FETCH", 1'b0, 1'b0, v(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0));
    play(rdy_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_post %s cyc%0d: got %b expected %b", tag_q[i], i, obs_q[i], exp_q[i]); end
      checks++;
      if (iobs_q[i] !== iexp_q[i]) begin errors++; $display("FAIL abort_post_instret cyc%0d: got %0d expected %0d", i, iobs_q[i], iexp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit t;
    logic [6:0] legal [8];
    logic [6:0] op;
    logic [2:0] f3;
    legal = '{LOAD, STORE, RTYP, ITYP, LUI, BR, JAL, JALR};
    clear_q();
    for (int n = 0; n < 40; n++) begin
      op = legal[$urandom_range(0, 7)];
      f3 = (op == BR) ? {2'b00, rb()} : 3'($urandom_range(0, 7));
      model_instr(op, f3, rb(), $urandom_range(0, 3), $urandom_range(0, 3), t);
    end
    push("NEXT_FETCH", 1'b0, 1'b0, v(1,0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0));
    play(rdy_q.size());
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random %s op=%b cyc%0d: got %b expected %b", tag_q[i], op_q[i], i, obs_q[i], exp_q[i]); end
      checks++;
      if (iobs_q[i] !== iexp_q[i]) begin errors++; $display("FAIL random_instret cyc%0d: got %0d expected %0d", i, iobs_q[i], iexp_q[i]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_jalr();
    test_branch();
    test_trap();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
